// File: rtl/lr_serial_comparator.sv
// MSB-first serial magnitude comparator.
// Scans one latched bit per clock and stops at the first difference.
module lr_serial_comparator #(
  parameter int K  = 4,
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [K-1:0]  A_valor,
  input  logic [K-1:0]  B_valor,
  output logic          busy,
  output logic          done,
  output logic          A_mayor,
  output logic          B_mayor,
  output logic          iguales,
  output logic [PW-1:0] pos
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [K-1:0]  ar_q, ar_d;
  logic [K-1:0]  br_q, br_d;
  logic [PW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          amay_q, amay_d;
  logic          bmay_q, bmay_d;
  logic          igu_q, igu_d;
  logic [PW-1:0] pos_q, pos_d;

  logic          bit_a;
  logic          bit_b;

  assign bit_a = ar_q[idx_q];
  assign bit_b = br_q[idx_q];

  // Next-state: accept in IDLE, walk one bit per cycle in SCAN.
  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    br_d    = br_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    amay_d  = amay_q;
    bmay_d  = bmay_q;
    igu_d   = igu_q;
    pos_d   = pos_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ar_d    = A_valor;
          br_d    = B_valor;
          idx_d   = PW'(K - 1);
          busy_d  = 1'b1;
          amay_d  = 1'b0;
          bmay_d  = 1'b0;
          igu_d   = 1'b0;
          pos_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (bit_a != bit_b) begin
          amay_d  = bit_a;
          bmay_d  = bit_b;
          pos_d   = idx_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          igu_d   = 1'b1;
          pos_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q - PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset abandons any scan silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ar_q    <= '0;
      br_q    <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      amay_q  <= 1'b0;
      bmay_q  <= 1'b0;
      igu_q   <= 1'b0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      br_q    <= br_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      amay_q  <= amay_d;
      bmay_q  <= bmay_d;
      igu_q   <= igu_d;
      pos_q   <= pos_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign A_mayor = amay_q;
  assign B_mayor = bmay_q;
  assign iguales = igu_q;
  assign pos     = pos_q;

endmodule

// File: tb/tb_lr_serial_comparator.sv
// Directed bench for lr_serial_comparator (K=4).
// Table of operand pairs plus hand sequences for multi-cycle cases.
module tb_lr_serial_comparator;

  localparam int K  = 4;
  localparam int PW = 2;

  logic          clk;
  logic          reset;
  logic          start;
  logic [K-1:0]  A_valor;
  logic [K-1:0]  B_valor;
  logic          busy;
  logic          done;
  logic          A_mayor;
  logic          B_mayor;
  logic          iguales;
  logic [PW-1:0] pos;

  int n_tests = 0;
  int n_fail  = 0;

  lr_serial_comparator #(.K(K), .PW(PW)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .A_valor (A_valor),
    .B_valor (B_valor),
    .busy    (busy),
    .done    (done),
    .A_mayor (A_mayor),
    .B_mayor (B_mayor),
    .iguales (iguales),
    .pos     (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [K-1:0]  a;
    logic [K-1:0]  b;
    logic [2:0]    flags;
    logic [PW-1:0] epos;
    int            lat;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Launch one compare; call right after an edge (+#1) with DUT idle.
  task automatic do_cmp(input vec_t v, input bit hold, input string tag);
    int lat;
    A_valor = v.a;
    B_valor = v.b;
    start   = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    chk({tag, " busy@accept"}, int'(busy), 1);
    chk({tag, " flags@accept"}, int'({A_mayor, B_mayor, iguales}), 0);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    chk({tag, " done seen"}, int'(done), 1);
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " flags"}, int'({A_mayor, B_mayor, iguales}), int'(v.flags));
    chk({tag, " pos"}, int'(pos), int'(v.epos));
    chk({tag, " busy@done"}, int'(busy), 0);
  endtask

  initial begin
    // flags = {A_mayor, B_mayor, iguales}
    vt[0] = '{4'b1111, 4'b1111, 3'b001, 2'd0, 4};
    vt[1] = '{4'b1101, 4'b1011, 3'b100, 2'd2, 2};
    vt[2] = '{4'b0000, 4'b1011, 3'b010, 2'd3, 1};
    vt[3] = '{4'b0001, 4'b0000, 3'b100, 2'd0, 4};
    vt[4] = '{4'b0110, 4'b0111, 3'b010, 2'd0, 4};
    vt[5] = '{4'b1000, 4'b0111, 3'b100, 2'd3, 1};
    vt[6] = '{4'b0100, 4'b0110, 3'b010, 2'd1, 3};
    vt[7] = '{4'b0000, 4'b0000, 3'b001, 2'd0, 4};

    reset   = 1'b1;
    start   = 1'b0;
    A_valor = '0;
    B_valor = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("reset idle", int'({busy, done, A_mayor, B_mayor, iguales, pos}), 0);
    end

    for (int i = 0; i < 8; i++) begin
      do_cmp(vt[i], 1'b0, $sformatf("vec%0d", i));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d done drop", i), int'(done), 0);
    end

    // Result holds while idle.
    do_cmp(vt[1], 1'b0, "hold");
    repeat (3) @(posedge clk);
    #1;
    chk("hold flags", int'({A_mayor, B_mayor, iguales}), 3'b100);
    chk("hold pos", int'(pos), 2);
    chk("hold done", int'(done), 0);

    // Operand change after acceptance is ignored.
    A_valor = 4'b0000;
    B_valor = 4'b1011;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    A_valor = 4'b1111;
    @(posedge clk);
    #1;
    chk("latch done", int'(done), 1);
    chk("latch flags", int'({A_mayor, B_mayor, iguales}), 3'b010);
    chk("latch pos", int'(pos), 3);

    // start held high across three pairs.
    for (int i = 0; i < 3; i++)
      do_cmp(vt[i], 1'b1, $sformatf("b2b%0d", i));
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b done drop", int'(done), 0);

    // Reset during second scan cycle abandons the compare.
    A_valor = 4'b1111;
    B_valor = 4'b1111;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid reset outs", int'({busy, done, A_mayor, B_mayor, iguales, pos}), 0);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk);
        #1;
        if (done) seen++;
      end
      chk("mid reset no done", seen, 0);
    end
    do_cmp(vt[3], 1'b0, "post reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
